// File: rtl/sram_bank_ctrl.sv
// Two-port controller for a banked SRAM array (port 0 RW for data OBI, port 1 R for instruction OBI).
// Define SRAM_OUT_REG_EN to add one response register stage on both ports (2-cycle latency).
module sram_bank_ctrl #(
  parameter logic [31:0] SRAM_BASE_ADDR      = 32'h8000_0000,
  parameter int unsigned SRAM_NUM_BLOCKS     = 4,
  parameter int unsigned SRAM_LOG_BLOCKS     = $clog2(SRAM_NUM_BLOCKS),
  parameter int unsigned SRAM_LOG_BLOCK_SIZE = 9,
  parameter logic [31:0] ERR_RDATA           = 32'hDEAD_BEEF,
  parameter int unsigned CNT_W               = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             sram_d_req_i,
  output logic             sram_d_gnt_o,
  input  logic [31:0]      sram_d_addr_i,
  input  logic             sram_d_we_i,
  input  logic [3:0]       sram_d_be_i,
  input  logic [31:0]      sram_d_wdata_i,
  output logic             sram_d_rvalid_o,
  output logic [31:0]      sram_d_rdata_o,
  output logic             sram_d_err_o,
  input  logic             sram_i_req_i,
  output logic             sram_i_gnt_o,
  input  logic [31:0]      sram_i_addr_i,
  output logic             sram_i_rvalid_o,
  output logic [31:0]      sram_i_rdata_o,
  output logic             sram_i_err_o,
  output logic             illegal_memory_o,
  output logic [CNT_W-1:0] illegal_count_o
);

  localparam int unsigned LB    = SRAM_LOG_BLOCKS;
  localparam int unsigned LW    = SRAM_LOG_BLOCK_SIZE;
  localparam int unsigned DEPTH = 1 << LW;
  localparam int unsigned TOP   = LB + LW + 2;
  localparam logic [32:0] LIMIT = 33'(SRAM_NUM_BLOCKS) << (LW + 2);

  logic [31:0]   d_off, i_off;
  logic          d_legal, i_legal, hazard;
  logic          d_gnt, i_gnt, d_acc, i_acc, d_ill_gnt, i_ill_gnt;
  logic [LB-1:0] d_bank, i_bank;

  // Unsigned subtraction makes addresses below the base wrap to huge offsets.
  assign d_off   = sram_d_addr_i - SRAM_BASE_ADDR;
  assign i_off   = sram_i_addr_i - SRAM_BASE_ADDR;
  assign d_legal = ({1'b0, d_off} < LIMIT);
  assign i_legal = ({1'b0, i_off} < LIMIT);
  assign d_bank  = d_off[TOP-1:LW+2];
  assign i_bank  = i_off[TOP-1:LW+2];

  assign hazard    = sram_d_req_i & sram_d_we_i & sram_i_req_i & d_legal & i_legal &
                     (d_off[TOP-1:2] == i_off[TOP-1:2]);
  assign d_gnt     = sram_d_req_i & ~rst_i;
  assign i_gnt     = sram_i_req_i & ~hazard & ~rst_i;
  assign d_acc     = d_gnt & d_legal;
  assign i_acc     = i_gnt & i_legal;
  assign d_ill_gnt = d_gnt & ~d_legal;
  assign i_ill_gnt = i_gnt & ~i_legal;

  assign sram_d_gnt_o = d_gnt;
  assign sram_i_gnt_o = i_gnt;

  // Macro-side signals: address/data/mask are shared, only csb is per bank.
  logic [SRAM_NUM_BLOCKS-1:0] csb0, csb1;
  logic                       web0;
  logic [3:0]                 wmask0;
  logic [LW-1:0]              addr0, addr1;
  logic [31:0]                din0;
  logic [31:0]                dout0 [SRAM_NUM_BLOCKS];
  logic [31:0]                dout1 [SRAM_NUM_BLOCKS];

  assign web0   = ~sram_d_we_i;
  assign wmask0 = sram_d_be_i;
  assign addr0  = d_off[LW+1:2];
  assign addr1  = i_off[LW+1:2];
  assign din0   = sram_d_wdata_i;

  always_comb begin
    csb0 = '1;
    csb1 = '1;
    if (d_acc) csb0[d_bank] = 1'b0;
    if (i_acc) csb1[i_bank] = 1'b0;
  end

  // Behavioural model of one 1rw1r macro per bank, read data registered on the clock edge.
  for (genvar b = 0; b < SRAM_NUM_BLOCKS; b++) begin : g_bank
    logic [31:0] mem [DEPTH];
    logic [31:0] dout0_q, dout1_q;

    always_ff @(posedge clk_i) begin
      if (!csb0[b]) begin
        if (!web0) begin
          for (int unsigned k = 0; k < 4; k++) begin
            if (wmask0[k]) mem[addr0][8*k +: 8] <= din0[8*k +: 8];
          end
        end else begin
          dout0_q <= mem[addr0];
        end
      end
      if (!csb1[b]) dout1_q <= mem[addr1];
    end

    assign dout0[b] = dout0_q;
    assign dout1[b] = dout1_q;
  end

  logic             d_vld_q, d_we_q, d_ill_q, i_vld_q, i_ill_q, ill_q;
  logic [LB-1:0]    d_bank_q, i_bank_q;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W:0]   cnt_sum;

  assign cnt_sum = {1'b0, cnt_q} + (CNT_W+1)'(d_ill_gnt) + (CNT_W+1)'(i_ill_gnt);
  assign cnt_d   = cnt_sum[CNT_W] ? '1 : cnt_sum[CNT_W-1:0];

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_vld_q  <= 1'b0;
      d_we_q   <= 1'b0;
      d_ill_q  <= 1'b0;
      d_bank_q <= '0;
      i_vld_q  <= 1'b0;
      i_ill_q  <= 1'b0;
      i_bank_q <= '0;
      ill_q    <= 1'b0;
      cnt_q    <= '0;
    end else begin
      d_vld_q  <= d_gnt;
      d_we_q   <= sram_d_we_i;
      d_ill_q  <= ~d_legal;
      d_bank_q <= d_bank;
      i_vld_q  <= i_gnt;
      i_ill_q  <= ~i_legal;
      i_bank_q <= i_bank;
      ill_q    <= d_ill_gnt | i_ill_gnt;
      cnt_q    <= cnt_d;
    end
  end

  logic [31:0] d_rdata_s, i_rdata_s;
  logic        d_err_s, i_err_s;

  always_comb begin
    d_rdata_s = '0;
    i_rdata_s = '0;
    if (d_vld_q) begin
      if (d_ill_q)      d_rdata_s = ERR_RDATA;
      else if (!d_we_q) d_rdata_s = dout0[d_bank_q];
    end
    if (i_vld_q) begin
      if (i_ill_q) i_rdata_s = ERR_RDATA;
      else         i_rdata_s = dout1[i_bank_q];
    end
  end

  assign d_err_s = d_vld_q & d_ill_q;
  assign i_err_s = i_vld_q & i_ill_q;

  logic        d_rvalid_r, d_err_r, i_rvalid_r, i_err_r;
  logic [31:0] d_rdata_r, i_rdata_r;

`ifdef SRAM_OUT_REG_EN
  logic        d_out_vld_q, d_out_err_q, i_out_vld_q, i_out_err_q;
  logic [31:0] d_out_rdata_q, i_out_rdata_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      d_out_vld_q   <= 1'b0;
      d_out_err_q   <= 1'b0;
      d_out_rdata_q <= '0;
      i_out_vld_q   <= 1'b0;
      i_out_err_q   <= 1'b0;
      i_out_rdata_q <= '0;
    end else begin
      d_out_vld_q   <= d_vld_q;
      d_out_err_q   <= d_err_s;
      d_out_rdata_q <= d_rdata_s;
      i_out_vld_q   <= i_vld_q;
      i_out_err_q   <= i_err_s;
      i_out_rdata_q <= i_rdata_s;
    end
  end

  assign d_rvalid_r = d_out_vld_q;
  assign d_err_r    = d_out_err_q;
  assign d_rdata_r  = d_out_rdata_q;
  assign i_rvalid_r = i_out_vld_q;
  assign i_err_r    = i_out_err_q;
  assign i_rdata_r  = i_out_rdata_q;
`else
  assign d_rvalid_r = d_vld_q;
  assign d_err_r    = d_err_s;
  assign d_rdata_r  = d_rdata_s;
  assign i_rvalid_r = i_vld_q;
  assign i_err_r    = i_err_s;
  assign i_rdata_r  = i_rdata_s;
`endif

  // Outputs are masked during reset so a response in flight at reset assertion never appears.
  assign sram_d_rvalid_o  = d_rvalid_r & ~rst_i;
  assign sram_d_err_o     = d_err_r & ~rst_i;
  assign sram_d_rdata_o   = rst_i ? '0 : d_rdata_r;
  assign sram_i_rvalid_o  = i_rvalid_r & ~rst_i;
  assign sram_i_err_o     = i_err_r & ~rst_i;
  assign sram_i_rdata_o   = rst_i ? '0 : i_rdata_r;
  assign illegal_memory_o = ill_q & ~rst_i;
  assign illegal_count_o  = rst_i ? '0 : cnt_q;

endmodule

// File: tb/tb_sram_bank_ctrl.sv
// Self-checking bench for sram_bank_ctrl: directed scenarios plus random traffic against a word-array model.
// Honours SRAM_OUT_REG_EN for the expected response latency.
module tb_sram_bank_ctrl;

  localparam logic [31:0] BASE  = 32'h8000_0000;
  localparam logic [31:0] ERR   = 32'hDEAD_BEEF;
  localparam int          WORDS = 2048;
`ifdef SRAM_OUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        d_req, d_gnt, d_we, d_rvalid, d_err;
  logic [31:0] d_addr, d_wdata, d_rdata;
  logic [3:0]  d_be;
  logic        i_req, i_gnt, i_rvalid, i_err;
  logic [31:0] i_addr, i_rdata;
  logic        ill_mem;
  logic [15:0] ill_cnt;

  sram_bank_ctrl #(
    .SRAM_BASE_ADDR(BASE),
    .SRAM_NUM_BLOCKS(4),
    .SRAM_LOG_BLOCK_SIZE(9),
    .ERR_RDATA(ERR),
    .CNT_W(16)
  ) dut (
    .clk_i(clk), .rst_i(rst),
    .sram_d_req_i(d_req), .sram_d_gnt_o(d_gnt), .sram_d_addr_i(d_addr),
    .sram_d_we_i(d_we), .sram_d_be_i(d_be), .sram_d_wdata_i(d_wdata),
    .sram_d_rvalid_o(d_rvalid), .sram_d_rdata_o(d_rdata), .sram_d_err_o(d_err),
    .sram_i_req_i(i_req), .sram_i_gnt_o(i_gnt), .sram_i_addr_i(i_addr),
    .sram_i_rvalid_o(i_rvalid), .sram_i_rdata_o(i_rdata), .sram_i_err_o(i_err),
    .illegal_memory_o(ill_mem), .illegal_count_o(ill_cnt)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic v; logic [31:0] rd; logic e;} resp_t;

  int          tests = 0, fails = 0;
  resp_t       pd [2], pi [2];
  logic [31:0] mem_m [WORDS];
  int unsigned cnt_m;
  logic        ill_m;
  bit          last_gi;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic bit legal(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return o < 32'd8192;
  endfunction

  function automatic int widx(input logic [31:0] a);
    logic [31:0] o;
    o = a - BASE;
    return int'(o >> 2);
  endfunction

  // One clock cycle with the currently driven inputs: check grants, advance model, check outputs.
  task automatic step();
    resp_t       nd, ni;
    bit          ld, li, gd, gi;
    int unsigned inc;
    logic [31:0] w;
    #1;
    ld = legal(d_addr);
    li = legal(i_addr);
    gd = d_req && !rst;
    gi = i_req && !rst && !(d_req && d_we && ld && li && widx(d_addr) == widx(i_addr));
    chk("d_gnt", d_gnt, gd);
    chk("i_gnt", i_gnt, gi);
    if (rst) begin
      chk("rst_d_rvalid", d_rvalid, 0);
      chk("rst_i_rvalid", i_rvalid, 0);
      chk("rst_d_rdata", d_rdata, 0);
      chk("rst_i_rdata", i_rdata, 0);
      chk("rst_ill_mem", ill_mem, 0);
    end
    nd = '0;
    ni = '0;
    if (gi) ni = li ? {1'b1, mem_m[widx(i_addr)], 1'b0} : {1'b1, ERR, 1'b1};
    if (gd) begin
      if (!ld) nd = {1'b1, ERR, 1'b1};
      else if (d_we) begin
        nd = {1'b1, 32'h0, 1'b0};
        w = mem_m[widx(d_addr)];
        for (int k = 0; k < 4; k++) if (d_be[k]) w[8*k +: 8] = d_wdata[8*k +: 8];
        mem_m[widx(d_addr)] = w;
      end else nd = {1'b1, mem_m[widx(d_addr)], 1'b0};
    end
    inc = ((gd && !ld) ? 1 : 0) + ((gi && !li) ? 1 : 0);
    @(posedge clk);
    #1;
    if (rst) begin
      pd[0] = '0; pd[1] = '0; pi[0] = '0; pi[1] = '0;
      cnt_m = 0;
      ill_m = 1'b0;
    end else begin
      pd[1] = pd[0]; pd[0] = nd;
      pi[1] = pi[0]; pi[0] = ni;
      cnt_m = (cnt_m + inc > 65535) ? 65535 : cnt_m + inc;
      ill_m = (inc != 0);
    end
    last_gi = gi;
    chk("d_rvalid", d_rvalid, pd[LAT-1].v);
    chk("d_rdata", d_rdata, pd[LAT-1].rd);
    chk("d_err", d_err, pd[LAT-1].e);
    chk("i_rvalid", i_rvalid, pi[LAT-1].v);
    chk("i_rdata", i_rdata, pi[LAT-1].rd);
    chk("i_err", i_err, pi[LAT-1].e);
    chk("ill_mem", ill_mem, ill_m);
    chk("ill_cnt", ill_cnt, cnt_m[15:0]);
  endtask

  task automatic drv_d(input logic rq, input logic we, input logic [31:0] a,
                       input logic [3:0] be, input logic [31:0] wd);
    d_req = rq; d_we = we; d_addr = a; d_be = be; d_wdata = wd;
  endtask

  task automatic drv_i(input logic rq, input logic [31:0] a);
    i_req = rq; i_addr = a;
  endtask

  task automatic idle();
    drv_d(0, 0, 32'h0, 4'h0, 32'h0);
    drv_i(0, 32'h0);
    rst = 1'b0;
    step();
  endtask

  function automatic logic [31:0] raddr();
    case ($urandom_range(0, 9))
      0:       return BASE - 32'($urandom_range(1, 400));
      1:       return BASE + 32'd8192 + 32'($urandom_range(0, 4000));
      default: return BASE + 32'($urandom_range(0, WORDS - 1) * 4) + 32'($urandom_range(0, 3));
    endcase
  endfunction

  initial begin
    int unsigned c0;
    pd[0] = '0; pd[1] = '0; pi[0] = '0; pi[1] = '0;
    cnt_m = 0; ill_m = 1'b0; last_gi = 1'b0;
    rst = 1'b1;
    drv_d(0, 0, 32'h0, 4'h0, 32'h0);
    drv_i(0, 32'h0);
    step();
    step();
    chk("reset_count", ill_cnt, 0);

    // Fill the whole window so every later read has a defined expected value.
    rst = 1'b0;
    for (int w = 0; w < WORDS; w++) begin
      drv_d(1, 1, BASE + 32'(w * 4), 4'hF, $urandom);
      step();
    end

    // Write then instruction read of the same word in bank 1.
    drv_d(1, 1, 32'h8000_0804, 4'hF, 32'h1234_5678);
    step();
    drv_d(0, 0, 32'h0, 4'h0, 32'h0);
    drv_i(1, 32'h8000_0804);
    step();
    for (int k = 1; k < LAT; k++) idle();
    chk("t1_rvalid", i_rvalid, 1);
    chk("t1_rdata", i_rdata, 32'h1234_5678);
    chk("t1_err", i_err, 0);

    // Same-word write/read hazard stalls the instruction port for one cycle.
    drv_d(1, 1, 32'h8000_0010, 4'hF, 32'hCAFE_0010);
    drv_i(1, 32'h8000_0010);
    #1 chk("t2_stall", i_gnt, 0);
    step();
    drv_d(0, 0, 32'h0, 4'h0, 32'h0);
    #1 chk("t2_regrant", i_gnt, 1);
    step();
    for (int k = 1; k < LAT; k++) idle();
    chk("t2_rdata", i_rdata, 32'hCAFE_0010);

    // Illegal accesses on both ports in the same cycle.
    c0 = cnt_m;
    drv_d(1, 0, 32'h8000_C000, 4'h0, 32'h0);
    drv_i(1, 32'h7FFF_FFFC);
    step();
    chk("t3_ill_pulse", ill_mem, 1);
    chk("t3_count", ill_cnt, 16'(c0 + 2));
    for (int k = 1; k < LAT; k++) idle();
    chk("t3_d_rdata", d_rdata, ERR);
    chk("t3_d_err", d_err, 1);
    chk("t3_i_rdata", i_rdata, ERR);
    chk("t3_i_err", i_err, 1);
    idle();
    chk("t3_ill_clear", ill_mem, 0);

    // Byte-enable merge and an all-zero byte-enable write.
    drv_i(0, 32'h0);
    drv_d(1, 1, 32'h8000_0100, 4'hF, 32'hFFFF_FFFF); step();
    drv_d(1, 1, 32'h8000_0100, 4'b0010, 32'hAABB_CCDD); step();
    drv_d(1, 1, 32'h8000_0100, 4'b0000, 32'h0000_0000); step();
    drv_d(1, 0, 32'h8000_0100, 4'h0, 32'h0); step();
    for (int k = 1; k < LAT; k++) idle();
    chk("t5_rdata", d_rdata, 32'hFFFF_CCFF);

    // Window boundaries: last legal word, first offset past the window, one byte below base.
    drv_d(1, 0, BASE + 32'd8188, 4'h0, 32'h0);
    drv_i(1, BASE - 32'd1);
    step();
    for (int k = 1; k < LAT; k++) idle();
    chk("bnd_last_err", d_err, 0);
    chk("bnd_below_err", i_err, 1);
    drv_d(1, 0, BASE + 32'd8192, 4'h0, 32'h0);
    drv_i(1, BASE + 32'd8191);
    step();
    for (int k = 1; k < LAT; k++) idle();
    chk("bnd_past_err", d_err, 1);
    chk("bnd_lastbyte_err", i_err, 0);

    // Reset the cycle after a read grant drops anything still in flight.
    drv_i(0, 32'h0);
    drv_d(1, 0, 32'h8000_0100, 4'h0, 32'h0);
    step();
    drv_d(0, 0, 32'h0, 4'h0, 32'h0);
    rst = 1'b1;
    step();
    for (int k = 0; k < 3; k++) begin
      idle();
      chk("t6_no_rvalid", d_rvalid, 0);
    end

    // Random traffic; a stalled instruction request is held unchanged.
    for (int n = 0; n < 3000; n++) begin
      drv_d($urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1, raddr(), 4'($urandom), $urandom);
      if (!(i_req && !last_gi)) begin
        i_req  = $urandom_range(0, 3) != 0;
        i_addr = ($urandom_range(0, 3) == 0) ? d_addr : raddr();
      end
      rst = ($urandom_range(0, 199) == 0);
      step();
    end

    // Drive illegal accesses on both ports until the counter saturates.
    rst = 1'b0;
    drv_d(1, 0, 32'h8000_C000, 4'h0, 32'h0);
    drv_i(1, 32'h7FFF_FFFC);
    for (int n = 0; n < 33000 && cnt_m < 65535; n++) step();
    chk("t4_sat", ill_cnt, 16'hFFFF);
    drv_i(0, 32'h0);
    step();
    chk("t4_hold", ill_cnt, 16'hFFFF);
    chk("t4_pulse", ill_mem, 1);
    idle();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
